alu_operand_stage: RTL and testbench

- Registered, parametrised successor to the combinational ALU input selector, for the pipelined core.
- Selects both ALU operands (A and B) from zero, four, PC, register data or one of four immediate formats.
- Applies EX/MEM result forwarding and stalls on pending load results.
- Holds the selected operands in a one-entry pipeline register with a valid/ready handshake toward the execute stage.

---
 rtl/alu_operand_pkg.sv | 49 ++++
 rtl/alu_operand_select.sv | 71 +++++++
 rtl/alu_operand_stage.sv | 110 +++++++++++
 tb/tb_alu_operand_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_pkg.sv
// Shared constants and instruction-field helpers for the ALU operand stage.
// Immediate helpers return a 64-bit sign-extended value. Callers cast the
// result down to their own XLEN, which gives the correct result for both
// XLEN=32 and XLEN=64.
package alu_operand_pkg;

    // Operand source select encoding, shared by operand A and operand B
    localparam logic [2:0] ALU_SRC_ZERO  = 3'b000;
    localparam logic [2:0] ALU_SRC_FOUR  = 3'b001;
    localparam logic [2:0] ALU_SRC_PC    = 3'b010;
    localparam logic [2:0] ALU_SRC_REG   = 3'b011;
    localparam logic [2:0] ALU_SRC_IMM_I = 3'b100;
    localparam logic [2:0] ALU_SRC_IMM_U = 3'b101;
    localparam logic [2:0] ALU_SRC_IMM_S = 3'b110;
    localparam logic [2:0] ALU_SRC_IMM_B = 3'b111;

    // Widest datapath supported by the helpers below
    localparam int MAX_XLEN = 64;

    // I-type immediate: instr[31:20]
    function automatic logic [MAX_XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    // U-type immediate: upper 20 bits, low 12 bits zero, sign from bit 31
    function automatic logic [MAX_XLEN-1:0] imm_u(input logic [31:0] instr);
        return {{32{instr[31]}}, instr[31:12], 12'b0};
    endfunction

    // S-type immediate: split 12-bit store offset
    function automatic logic [MAX_XLEN-1:0] imm_s(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    // B-type immediate: 13-bit branch offset, bit 0 always zero
    function automatic logic [MAX_XLEN-1:0] imm_b(input logic [31:0] instr);
        return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // Register index fields
    function automatic logic [4:0] rs1_idx(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_idx(input logic [31:0] instr);
        return instr[24:20];
    endfunction

endpackage

// File: rtl/alu_operand_select.sv
// Combinational selection of one ALU operand: source mux, forwarding
// priority (lowest index wins) and the load-use hazard flag for that operand.
module alu_operand_select
    import alu_operand_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [2:0]              i_src,
    input  logic [31:0]             i_instr,
    input  logic [XLEN-1:0]         i_pc,
    input  logic [4:0]              i_reg_idx,
    input  logic [XLEN-1:0]         i_reg_data,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD-1:0]      i_fwd_pending,
    input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
    output logic [XLEN-1:0]         o_operand,
    output logic                    o_hazard
);

    logic [NUM_FWD-1:0] w_match;
    logic [XLEN-1:0]    w_reg_value;
    logic               w_win_pending;

    // Opcode bits play no part in operand selection
    logic w_unused_opcode;
    assign w_unused_opcode = &{1'b0, i_instr[6:0]};

    // Per-entry match: valid entry writing the register we read
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign w_match[gi] = i_fwd_valid[gi] && (i_fwd_rd[5*gi +: 5] == i_reg_idx);
        end
    endgenerate

    // Priority pick: scan from oldest to youngest so the lowest index wins;
    // x0 is hard-wired and never takes a forwarded value
    always_comb begin
        w_reg_value   = i_reg_data;
        w_win_pending = 1'b0;
        if (i_reg_idx != 5'd0) begin
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (w_match[i]) begin
                    w_reg_value   = i_fwd_data[XLEN*i +: XLEN];
                    w_win_pending = i_fwd_pending[i];
                end
            end
        end
    end

    // Source mux
    always_comb begin
        o_operand = '0;
        case (i_src)
            ALU_SRC_ZERO:  o_operand = '0;
            ALU_SRC_FOUR:  o_operand = XLEN'(4);
            ALU_SRC_PC:    o_operand = i_pc;
            ALU_SRC_REG:   o_operand = w_reg_value;
            ALU_SRC_IMM_I: o_operand = XLEN'(imm_i(i_instr));
            ALU_SRC_IMM_U: o_operand = XLEN'(imm_u(i_instr));
            ALU_SRC_IMM_S: o_operand = XLEN'(imm_s(i_instr));
            ALU_SRC_IMM_B: o_operand = XLEN'(imm_b(i_instr));
            default:       o_operand = '0;
        endcase
    end

    // A stall is only needed when the register value is actually used
    assign o_hazard = (i_src == ALU_SRC_REG) && w_win_pending;

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: selects operands A and B with forwarding,
// stalls on pending load results and holds the result in a one-entry
// pipeline register with a valid/ready handshake toward execute.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_instr_addr,
    input  logic [31:0]             in_instr,
    input  logic [2:0]              in_src_a,
    input  logic [2:0]              in_src_b,
    input  logic [XLEN-1:0]         in_rs1_data,
    input  logic [XLEN-1:0]         in_rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_op_a,
    output logic [XLEN-1:0]         out_op_b,
    output logic [31:0]             out_instr
);

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic            w_hazard_a;
    logic            w_hazard_b;
    logic            w_hazard;
    logic            w_accept;

    logic            r_out_valid;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [31:0]     r_instr;

    // Operand A reads rs1
    alu_operand_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_sel_a (
        .i_src         (in_src_a),
        .i_instr       (in_instr),
        .i_pc          (in_instr_addr),
        .i_reg_idx     (rs1_idx(in_instr)),
        .i_reg_data    (in_rs1_data),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_pending (fwd_pending),
        .i_fwd_rd      (fwd_rd),
        .i_fwd_data    (fwd_data),
        .o_operand     (w_op_a),
        .o_hazard      (w_hazard_a)
    );

    // Operand B reads rs2
    alu_operand_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_sel_b (
        .i_src         (in_src_b),
        .i_instr       (in_instr),
        .i_pc          (in_instr_addr),
        .i_reg_idx     (rs2_idx(in_instr)),
        .i_reg_data    (in_rs2_data),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_pending (fwd_pending),
        .i_fwd_rd      (fwd_rd),
        .i_fwd_data    (fwd_data),
        .o_operand     (w_op_b),
        .o_hazard      (w_hazard_b)
    );

    // Hazard is purely combinational on the current inputs
    assign w_hazard = w_hazard_a || w_hazard_b;
    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Pipeline register: flush beats accept, accept beats drain;
    // data only moves on an accepted (unflushed) transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_instr     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op_a      <= w_op_a;
            r_op_b      <= w_op_b;
            r_instr     <= in_instr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_op_a  = r_op_a;
    assign out_op_b  = r_op_b;
    assign out_instr = r_instr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: table of single-transfer vectors
// plus hand-written stall, backpressure, flush, reset and XLEN=64 sequences.
module tb_alu_operand_stage;

    logic        clk;
    logic        reset;

    // XLEN=32 instance signals
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr_addr;
    logic [31:0] in_instr;
    logic [2:0]  in_src_a;
    logic [2:0]  in_src_b;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [1:0]  fwd_valid;
    logic [1:0]  fwd_pending;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [31:0] out_instr;

    // XLEN=64 instance signals
    logic         flush_64;
    logic         in_valid_64;
    logic         in_ready_64;
    logic [63:0]  in_instr_addr_64;
    logic [31:0]  in_instr_64;
    logic [2:0]   in_src_a_64;
    logic [2:0]   in_src_b_64;
    logic [63:0]  in_rs1_data_64;
    logic [63:0]  in_rs2_data_64;
    logic [1:0]   fwd_valid_64;
    logic [1:0]   fwd_pending_64;
    logic [9:0]   fwd_rd_64;
    logic [127:0] fwd_data_64;
    logic         out_valid_64;
    logic         out_ready_64;
    logic [63:0]  out_op_a_64;
    logic [63:0]  out_op_b_64;
    logic [31:0]  out_instr_64;

    int n_tests = 0;
    int n_fail  = 0;

    alu_operand_stage #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr_addr (in_instr_addr),
        .in_instr      (in_instr),
        .in_src_a      (in_src_a),
        .in_src_b      (in_src_b),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .fwd_valid     (fwd_valid),
        .fwd_pending   (fwd_pending),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op_a      (out_op_a),
        .out_op_b      (out_op_b),
        .out_instr     (out_instr)
    );

    alu_operand_stage #(.XLEN(64), .NUM_FWD(2)) dut64 (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush_64),
        .in_valid      (in_valid_64),
        .in_ready      (in_ready_64),
        .in_instr_addr (in_instr_addr_64),
        .in_instr      (in_instr_64),
        .in_src_a      (in_src_a_64),
        .in_src_b      (in_src_b_64),
        .in_rs1_data   (in_rs1_data_64),
        .in_rs2_data   (in_rs2_data_64),
        .fwd_valid     (fwd_valid_64),
        .fwd_pending   (fwd_pending_64),
        .fwd_rd        (fwd_rd_64),
        .fwd_data      (fwd_data_64),
        .out_valid     (out_valid_64),
        .out_ready     (out_ready_64),
        .out_op_a      (out_op_a_64),
        .out_op_b      (out_op_b_64),
        .out_instr     (out_instr_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src_a;
        logic [2:0]  src_b;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  fv;
        logic [1:0]  fp;
        logic [9:0]  frd;
        logic [63:0] fdata;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fwd_rd packing: entry1 in [9:5], entry0 in [4:0]
        // fwd_data packing: entry1 in [63:32], entry0 in [31:0]
        //            src_a   src_b   pc          instr         rs1        rs2        fv     fp     frd     fdata                    exp_a         exp_b
        vecs[0]  = '{3'b010, 3'b100, 32'h100,  32'hFFF00093, 32'h0,    32'h0,    2'b00, 2'b00, 10'h000, 64'h0,                  32'h100,      32'hFFFFFFFF};
        vecs[1]  = '{3'b011, 3'b000, 32'h0,    32'h00028000, 32'h11,   32'h22,   2'b11, 2'b00, 10'h0A5, 64'h000000BB_000000AA,  32'hAA,       32'h0};
        vecs[2]  = '{3'b011, 3'b001, 32'h0,    32'h00000000, 32'h1234, 32'h0,    2'b01, 2'b00, 10'h000, 64'h000000BB_000000AA,  32'h1234,     32'h4};
        vecs[3]  = '{3'b011, 3'b011, 32'h0,    32'h00728000, 32'h11,   32'h22,   2'b11, 2'b00, 10'h0A7, 64'h000000BB_000000AA,  32'hBB,       32'hAA};
        vecs[4]  = '{3'b011, 3'b011, 32'h0,    32'h00728000, 32'h55,   32'h77,   2'b00, 2'b00, 10'h0A7, 64'h000000BB_000000AA,  32'h55,       32'h77};
        vecs[5]  = '{3'b101, 3'b110, 32'h0,    32'hFE000F23, 32'h0,    32'h0,    2'b00, 2'b00, 10'h000, 64'h0,                  32'hFE000000, 32'hFFFFFFFE};
        vecs[6]  = '{3'b100, 3'b111, 32'h0,    32'hFE000CE3, 32'h0,    32'h0,    2'b00, 2'b00, 10'h000, 64'h0,                  32'hFFFFFFE0, 32'hFFFFFFF8};
        vecs[7]  = '{3'b101, 3'b100, 32'h0,    32'h12300093, 32'h0,    32'h0,    2'b00, 2'b00, 10'h000, 64'h0,                  32'h12300000, 32'h00000123};
        vecs[8]  = '{3'b011, 3'b010, 32'h2000, 32'h00028000, 32'h11,   32'h0,    2'b11, 2'b10, 10'h0A5, 64'h000000BB_000000AA,  32'hAA,       32'h2000};
        vecs[9]  = '{3'b000, 3'b001, 32'h0,    32'h00028000, 32'h11,   32'h0,    2'b01, 2'b01, 10'h0A5, 64'h000000BB_000000AA,  32'h0,        32'h4};
        vecs[10] = '{3'b011, 3'b000, 32'h0,    32'h00000000, 32'h99,   32'h0,    2'b01, 2'b01, 10'h000, 64'h000000BB_000000AA,  32'h99,       32'h0};

        reset = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr_addr = '0; in_instr = '0; in_src_a = '0; in_src_b = '0;
        in_rs1_data = '0; in_rs2_data = '0;
        fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
        flush_64 = 1'b0; in_valid_64 = 1'b0; out_ready_64 = 1'b1;
        in_instr_addr_64 = '0; in_instr_64 = '0; in_src_a_64 = '0; in_src_b_64 = '0;
        in_rs1_data_64 = '0; in_rs2_data_64 = '0;
        fwd_valid_64 = '0; fwd_pending_64 = '0; fwd_rd_64 = '0; fwd_data_64 = '0;

        // Reset state
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_op_a",  64'(out_op_a),  64'd0);
        chk("reset_op_b",  64'(out_op_b),  64'd0);
        chk("reset_instr", 64'(out_instr), 64'd0);
        #3 reset = 1'b0;
        step();

        // Table-driven single transfers with out_ready held high
        for (int v = 0; v < NVEC; v++) begin
            in_valid      = 1'b1;
            in_src_a      = vecs[v].src_a;
            in_src_b      = vecs[v].src_b;
            in_instr_addr = vecs[v].pc;
            in_instr      = vecs[v].instr;
            in_rs1_data   = vecs[v].rs1;
            in_rs2_data   = vecs[v].rs2;
            fwd_valid     = vecs[v].fv;
            fwd_pending   = vecs[v].fp;
            fwd_rd        = vecs[v].frd;
            fwd_data      = vecs[v].fdata;
            #4;
            chk($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd1);
            step();
            chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_op_a", v),  64'(out_op_a),  64'(vecs[v].exp_a));
            chk($sformatf("vec%0d_op_b", v),  64'(out_op_b),  64'(vecs[v].exp_b));
            chk($sformatf("vec%0d_instr", v), 64'(out_instr), 64'(vecs[v].instr));
            $display("[TB] vec %0d instr=%h op_a=%h op_b=%h", v, out_instr, out_op_a, out_op_b);
        end

        // Drain the register
        in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Load stall: entry0 pending on rs2, entry1 matches but is ready
        in_valid    = 1'b1;
        in_src_a    = 3'b000;
        in_src_b    = 3'b011;
        in_instr    = 32'h00700000;
        fwd_valid   = 2'b11;
        fwd_pending = 2'b01;
        fwd_rd      = 10'h0E7;
        fwd_data    = 64'h00001111_0000DEAD;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            step();
            chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd0);
        end
        fwd_pending = 2'b00;
        #4;
        chk("stall_release_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("stall_release_valid", 64'(out_valid), 64'd1);
        chk("stall_release_op_b",  64'(out_op_b),  64'h0000DEAD);
        $display("[TB] stall release op_b=%h", out_op_b);

        // Backpressure: held entry stays stable while out_ready is low
        out_ready     = 1'b0;
        fwd_valid     = 2'b00;
        in_src_a      = 3'b001;
        in_src_b      = 3'b010;
        in_instr_addr = 32'h300;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
            step();
            chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_op_b", c),  64'(out_op_b),  64'h0000DEAD);
        end
        out_ready = 1'b1;
        #4;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("b2b0_valid", 64'(out_valid), 64'd1);
        chk("b2b0_op_a",  64'(out_op_a),  64'd4);
        chk("b2b0_op_b",  64'(out_op_b),  64'h300);
        $display("[TB] back-to-back 0 op_b=%h", out_op_b);
        in_instr_addr = 32'h304;
        #4;
        chk("b2b1_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("b2b1_valid", 64'(out_valid), 64'd1);
        chk("b2b1_op_b",  64'(out_op_b),  64'h304);
        $display("[TB] back-to-back 1 op_b=%h", out_op_b);
        in_valid = 1'b0;
        step();
        chk("b2b_drain_valid", 64'(out_valid), 64'd0);

        // Flush coincident with an accept drops the input
        in_valid      = 1'b1;
        in_instr_addr = 32'h400;
        flush         = 1'b1;
        #4;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_op_b",  64'(out_op_b),  64'h304);
        $display("[TB] flush+accept valid=%0d", out_valid);

        // Reset asserted while an entry is held
        in_instr_addr = 32'h600;
        in_instr      = 32'h00000013;
        step();
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_op_b",  64'(out_op_b),  64'h600);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midreset_valid", 64'(out_valid), 64'd0);
        chk("midreset_op_a",  64'(out_op_a),  64'd0);
        chk("midreset_op_b",  64'(out_op_b),  64'd0);
        chk("midreset_instr", 64'(out_instr), 64'd0);
        $display("[TB] mid-hold reset valid=%0d", out_valid);
        reset         = 1'b0;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        in_instr_addr = 32'h700;
        step();
        chk("post_reset_valid", 64'(out_valid), 64'd1);
        chk("post_reset_op_b",  64'(out_op_b),  64'h700);
        $display("[TB] first accept after reset op_b=%h", out_op_b);
        in_valid = 1'b0;

        // XLEN=64 immediates
        in_valid_64      = 1'b1;
        in_src_a_64      = 3'b010;
        in_src_b_64      = 3'b101;
        in_instr_addr_64 = 64'h1_0000_0000;
        in_instr_64      = 32'h800002B7;
        step();
        chk("x64_u_valid", 64'(out_valid_64), 64'd1);
        chk("x64_u_op_a",  out_op_a_64, 64'h0000000100000000);
        chk("x64_u_op_b",  out_op_b_64, 64'hFFFFFFFF80000000);
        $display("[TB] x64 U op_b=%h", out_op_b_64);
        in_src_a_64 = 3'b100;
        in_src_b_64 = 3'b111;
        in_instr_64 = 32'hFE000CE3;
        step();
        chk("x64_b_op_a", out_op_a_64, 64'hFFFFFFFFFFFFFFE0);
        chk("x64_b_op_b", out_op_b_64, 64'hFFFFFFFFFFFFFFF8);
        $display("[TB] x64 B op_b=%h", out_op_b_64);
        in_valid_64 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
